sdram_pattern_engine: RTL and testbench



---
 rtl/sdram_pattern_engine_pkg.sv | 27 ++
 rtl/sdram_pattern_checker.sv | 52 +++++
 rtl/sdram_pattern_engine.sv | 183 ++++++++++++++++++
 tb/tb_sdram_pattern_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pattern_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pattern_engine_pkg
// Description : Shared state encoding and pattern generator for the SDRAM
//               pattern engine and its checker.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pattern_engine_pkg;

    // Run sequencer states; 3 bits covers the five states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_REQ  = 3'd2,
        READ_WAIT = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Word i of the test region carries seed + i; callers truncate to the
    // data width, which yields the modulo-2^DATA_W wrap.
    function automatic logic [63:0] pat(input logic [63:0] seed,
                                        input logic [63:0] index);
        return seed + index;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pattern_checker
// Description : Compares returned read data with the expected pattern word,
//               keeps a saturating mismatch count and captures the address
//               of the first mismatch of a run.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_pattern_checker #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int ERR_W     = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              check_en,
    input  logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] expected,
    input  logic [ADDR_W-1:0] cur_addr,
    output logic              mismatch,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // Flagged only for a word actually being checked this cycle.
    assign mismatch = check_en && (readdata != expected);

    // Saturating error counter and first-fail address capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_count     <= '0;
            first_fail_addr <= BASE;
        end else if (clear) begin
            error_count     <= '0;
            first_fail_addr <= BASE;
        end else if (mismatch) begin
            if (error_count != '1) begin
                error_count <= error_count + 1'b1;
            end
            // A zero count means this is the first mismatch of the run.
            if (error_count == '0) begin
                first_fail_addr <= cur_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pattern_engine
// Description : On a rising edge of start, fills an SDRAM region with a
//               seed+index pattern through an Avalon-MM master, reads it back
//               one word at a time and reports done/pass/error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_pattern_engine
    import sdram_pattern_engine_pkg::*;
#(
    parameter int          ADDR_W    = 22,
    parameter int          DATA_W    = 16,
    parameter int          BASE_ADDR = 0,
    parameter int          NUM_WORDS = 1024,
    parameter int unsigned SEED      = 16'hA5A5,
    parameter int          ERR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [DATA_W-1:0] SEED_W   = DATA_W'(SEED);

    state_t            state, state_nxt;
    logic              start_q;
    logic [ADDR_W-1:0] index, index_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [DATA_W-1:0] writedata_nxt;
    logic              write_nxt, read_nxt;
    logic              done_nxt, pass_nxt;
    logic              rise;
    logic              clear;
    logic              check_en;
    logic              mismatch;
    logic [DATA_W-1:0] expected;

    assign rise     = start & ~start_q;
    assign busy     = (state == WRITE) || (state == READ_REQ) || (state == READ_WAIT);
    assign expected = DATA_W'(pat(64'(SEED), 64'(index)));

    // State and registered Avalon/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            index         <= '0;
            avm_address   <= BASE;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state         <= state_nxt;
            start_q       <= start;
            index         <= index_nxt;
            avm_address   <= address_nxt;
            avm_writedata <= writedata_nxt;
            avm_write     <= write_nxt;
            avm_read      <= read_nxt;
            done          <= done_nxt;
            pass          <= pass_nxt;
        end
    end

    // Next-state and next-output decode for the fill/read-back sequence.
    always_comb begin
        state_nxt     = state;
        index_nxt     = index;
        address_nxt   = avm_address;
        writedata_nxt = avm_writedata;
        write_nxt     = avm_write;
        read_nxt      = avm_read;
        done_nxt      = done;
        pass_nxt      = pass;
        clear         = 1'b0;
        check_en      = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt     = WRITE;
                    index_nxt     = '0;
                    clear         = 1'b1;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    write_nxt     = 1'b1;
                    address_nxt   = BASE;
                    writedata_nxt = SEED_W;
                end
            end

            WRITE: begin
                if (!avm_waitrequest) begin
                    if (index == LAST_IDX) begin
                        state_nxt   = READ_REQ;
                        index_nxt   = '0;
                        write_nxt   = 1'b0;
                        read_nxt    = 1'b1;
                        address_nxt = BASE;
                    end else begin
                        // Next word presented straight away: no bubble.
                        index_nxt     = index + 1'b1;
                        address_nxt   = BASE + index + 1'b1;
                        writedata_nxt = DATA_W'(pat(64'(SEED), 64'(index) + 64'd1));
                    end
                end
            end

            READ_REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt = READ_WAIT;
                    read_nxt  = 1'b0;
                end
            end

            READ_WAIT: begin
                if (avm_readdatavalid) begin
                    check_en = 1'b1;
                    if (index == LAST_IDX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        // Count is pre-update, so fold in this word's result.
                        pass_nxt  = (error_count == '0) && !mismatch;
                    end else begin
                        state_nxt   = READ_REQ;
                        index_nxt   = index + 1'b1;
                        read_nxt    = 1'b1;
                        address_nxt = avm_address + 1'b1;
                    end
                end
            end

            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                write_nxt = 1'b0;
                read_nxt  = 1'b0;
            end
        endcase
    end

    sdram_pattern_checker #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ERR_W     (ERR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_checker (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (clear),
        .check_en        (check_en),
        .readdata        (avm_readdata),
        .expected        (expected),
        .cur_addr        (avm_address),
        .mismatch        (mismatch),
        .error_count     (error_count),
        .first_fail_addr (first_fail_addr)
    );

endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_pattern_engine
// Description : Directed self-checking bench with an Avalon-MM slave model
//               (stall and corruption controls) plus a second instance with a
//               2-bit error counter against an always-corrupting slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_pattern_engine;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic start_sat = 1'b0;

    always #5 clk = ~clk;

    // Main DUT signals
    logic              busy, done, pass;
    logic [15:0]       error_count;
    logic [ADDR_W-1:0] first_fail_addr, avm_address;
    logic              avm_write, avm_read, avm_readdatavalid, avm_waitrequest;
    logic [DATA_W-1:0] avm_writedata, avm_readdata;

    // Saturation DUT signals
    logic              s_busy, s_done, s_pass;
    logic [1:0]        s_error_count;
    logic [ADDR_W-1:0] s_first_fail_addr, s_address;
    logic              s_write, s_read, s_rdvalid;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;

    sdram_pattern_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0),
        .NUM_WORDS(8), .SEED(16'h0001), .ERR_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_fail_addr(first_fail_addr),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest)
    );

    sdram_pattern_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0),
        .NUM_WORDS(8), .SEED(16'h0001), .ERR_W(2)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start_sat),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .error_count(s_error_count), .first_fail_addr(s_first_fail_addr),
        .avm_address(s_address), .avm_write(s_write),
        .avm_writedata(s_writedata), .avm_read(s_read),
        .avm_readdata(s_readdata), .avm_readdatavalid(s_rdvalid),
        .avm_waitrequest(1'b0)
    );

    // ---------------- slave model for the main DUT ----------------
    logic [DATA_W-1:0] mem [0:7];
    logic [ADDR_W-1:0] stall_addr = '1;
    int                stall_len  = 0;
    int                stall_seen;
    logic [ADDR_W-1:0] corrupt_addr = '1;
    logic              log_clr = 1'b0;
    int                wr_cnt, rd_cnt, hold_cnt;
    logic [ADDR_W-1:0] wr_addr [0:15];
    logic [DATA_W-1:0] wr_data [0:15];
    logic              rd_pending;
    logic [DATA_W-1:0] rd_q;

    assign avm_waitrequest   = avm_write && (avm_address == stall_addr) && (stall_seen < stall_len);
    assign avm_readdatavalid = rd_pending;
    assign avm_readdata      = rd_q;

    // Zero/stalled-wait slave with read latency one, logging accepted writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_seen <= 0;
            wr_cnt     <= 0;
            rd_cnt     <= 0;
            hold_cnt   <= 0;
            rd_pending <= 1'b0;
            rd_q       <= '0;
        end else begin
            if (!avm_write)           stall_seen <= 0;
            else if (avm_waitrequest) stall_seen <= stall_seen + 1;
            if (log_clr) begin
                wr_cnt   <= 0;
                rd_cnt   <= 0;
                hold_cnt <= 0;
            end else begin
                if (avm_write && avm_address == 22'd3 && avm_writedata == 16'd4)
                    hold_cnt <= hold_cnt + 1;
                if (avm_write && !avm_waitrequest) begin
                    if (wr_cnt < 16) begin
                        wr_addr[wr_cnt] <= avm_address;
                        wr_data[wr_cnt] <= avm_writedata;
                    end
                    wr_cnt <= wr_cnt + 1;
                end
                if (avm_read && !avm_waitrequest) rd_cnt <= rd_cnt + 1;
            end
            if (avm_write && !avm_waitrequest) mem[avm_address[2:0]] <= avm_writedata;
            rd_pending <= avm_read && !avm_waitrequest;
            if (avm_read && !avm_waitrequest)
                rd_q <= (avm_address == corrupt_addr) ? 16'h0000 : mem[avm_address[2:0]];
        end
    end

    // Slave for the saturation DUT: every read returns a non-pattern word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_rdvalid  <= 1'b0;
            s_readdata <= '0;
        end else begin
            s_rdvalid  <= s_read;
            s_readdata <= 16'hFFFF;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: done=%0b required 1", name, done);
        end
    endtask

    task automatic launch();
        start = 1'b0;
        repeat (2) @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
        start = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %0b required 0", done); end
        n_cmp++; if (pass !== 1'b0)  begin n_bad++; $display("FAIL reset_pass: got %0b required 0", pass); end
        n_cmp++; if (error_count !== 16'd0) begin n_bad++; $display("FAIL reset_err: got %0d required 0", error_count); end
        n_cmp++; if (first_fail_addr !== 22'd0) begin n_bad++; $display("FAIL reset_ffa: got %0d required 0", first_fail_addr); end
        n_cmp++; if ({avm_write, avm_read} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_rd: got %b required 00", {avm_write, avm_read}); end
        n_cmp++; if (avm_address !== 22'd0 || avm_writedata !== 16'd0) begin n_bad++; $display("FAIL reset_addr_data: got %0d/%0d required 0/0", avm_address, avm_writedata); end
    endtask

    task automatic test_basic();
        launch();
        wait_done("basic");
        n_cmp++; if (wr_cnt !== 8) begin n_bad++; $display("FAIL basic_wr_cnt: got %0d required 8", wr_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 22'(i) || wr_data[i] !== 16'(i + 1)) begin
                n_bad++;
                $display("FAIL basic_write%0d: got addr %0d data %0d required %0d/%0d", i, wr_addr[i], wr_data[i], i, i + 1);
            end
        end
        n_cmp++; if (rd_cnt !== 8) begin n_bad++; $display("FAIL basic_rd_cnt: got %0d required 8", rd_cnt); end
        n_cmp++; if (pass !== 1'b1 || error_count !== 16'd0) begin n_bad++; $display("FAIL basic_result: got pass %0b err %0d required 1/0", pass, error_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %0b required 0", busy); end
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done_idle: got %0b required 1", done); end
    endtask

    task automatic test_stall();
        stall_addr = 22'd3;
        stall_len  = 3;
        launch();
        wait_done("stall");
        n_cmp++; if (hold_cnt !== 4) begin n_bad++; $display("FAIL stall_hold: got %0d cycles required 4", hold_cnt); end
        n_cmp++; if (wr_cnt !== 8 || wr_data[3] !== 16'd4 || wr_data[4] !== 16'd5) begin n_bad++; $display("FAIL stall_writes: got cnt %0d d3 %0d d4 %0d required 8/4/5", wr_cnt, wr_data[3], wr_data[4]); end
        n_cmp++; if (pass !== 1'b1 || error_count !== 16'd0) begin n_bad++; $display("FAIL stall_result: got pass %0b err %0d required 1/0", pass, error_count); end
        stall_len  = 0;
        stall_addr = '1;
    endtask

    task automatic test_corrupt();
        corrupt_addr = 22'd5;
        launch();
        wait_done("corrupt");
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL corrupt_pass: got %0b required 0", pass); end
        n_cmp++; if (error_count !== 16'd1) begin n_bad++; $display("FAIL corrupt_err: got %0d required 1", error_count); end
        n_cmp++; if (first_fail_addr !== 22'd5) begin n_bad++; $display("FAIL corrupt_ffa: got %0d required 5", first_fail_addr); end
        corrupt_addr = '1;
    endtask

    task automatic test_saturate();
        int k;
        start_sat = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_done) break;
        end
        n_cmp++; if (s_done !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %0b required 1", s_done); end
        n_cmp++; if (s_error_count !== 2'd3) begin n_bad++; $display("FAIL sat_err: got %0d required 3", s_error_count); end
        n_cmp++; if (s_first_fail_addr !== 22'd0 || s_pass !== 1'b0) begin n_bad++; $display("FAIL sat_ffa_pass: got %0d/%0b required 0/0", s_first_fail_addr, s_pass); end
        start_sat = 1'b0;
    endtask

    task automatic test_start_pulses();
        int k;
        launch();
        repeat (3) @(negedge clk);
        n_cmp++; if (avm_write !== 1'b1) begin n_bad++; $display("FAIL pulse_in_write: got write %0b required 1", avm_write); end
        start = 1'b0; @(negedge clk);
        start = 1'b1; @(negedge clk);
        for (k = 0; k < 100; k++) begin
            if (avm_read) break;
            @(negedge clk);
        end
        start = 1'b0; @(negedge clk);
        start = 1'b1; @(negedge clk);
        wait_done("pulse");
        n_cmp++; if (wr_cnt !== 8 || rd_cnt !== 8) begin n_bad++; $display("FAIL pulse_ignored: got wr %0d rd %0d required 8/8", wr_cnt, rd_cnt); end
        repeat (10) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || wr_cnt !== 8) begin n_bad++; $display("FAIL held_high: got done %0b busy %0b wr %0d required 1/0/8", done, busy, wr_cnt); end
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL low_idle: got done %0b busy %0b required 1/0", done, busy); end
        start = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rerun_rise: got done %0b busy %0b required 0/1", done, busy); end
        wait_done("rerun");
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL rerun_pass: got %0b required 1", pass); end
    endtask

    task automatic test_async_reset();
        int k;
        corrupt_addr = 22'd2;
        launch();
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_cnt == 5 && !avm_read) break;
        end
        n_cmp++; if (avm_address !== 22'd4 || error_count !== 16'd1) begin n_bad++; $display("FAIL pre_reset: got addr %0d err %0d required 4/1", avm_address, error_count); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_bad++; $display("FAIL areset_status: got %0b%0b%0b required 000", busy, done, pass); end
        n_cmp++; if (error_count !== 16'd0 || first_fail_addr !== 22'd0) begin n_bad++; $display("FAIL areset_err: got %0d/%0d required 0/0", error_count, first_fail_addr); end
        n_cmp++; if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 22'd0) begin n_bad++; $display("FAIL areset_avm: got r%0b w%0b a%0d required 0/0/0", avm_read, avm_write, avm_address); end
        corrupt_addr = '1;
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        launch();
        wait_done("post_reset");
        n_cmp++; if (wr_cnt !== 8 || rd_cnt !== 8 || pass !== 1'b1) begin n_bad++; $display("FAIL post_reset_run: got wr %0d rd %0d pass %0b required 8/8/1", wr_cnt, rd_cnt, pass); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_corrupt();
        test_saturate();
        test_start_pulses();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
